// File: rtl/overlap_add_stream.sv
// -----------------------------------------------------------------------------
// overlap_add_stream
// Overlap-add stage for an AAC decoder: windowed IMDCT frames of
// 2*HALF_WINDOW_SIZE samples arrive as beats of LANES samples. The first half
// of each frame is added lane-wise to the stored second half of the previous
// frame and streamed out as PCM; the second half is written into the overlap
// buffer for the next frame.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   clear      synchronous frame clear (zero buffer, restart frame)
//   in_valid   / in_ready  / in_data   input beat stream
//   out_valid  / out_ready / out_data  overlap-added output stream
//   out_first  marks the first output beat of a frame
//   sat_flag   sticky overflow indicator since last reset/clear
//
// Handshake: a beat moves when valid && ready are both high at a rising
// clock edge; a source holds valid and data stable until that happens.
// -----------------------------------------------------------------------------
module overlap_add_stream #(
  parameter int WORD_LENGTH      = 16,
  parameter int LANES            = 4,
  parameter int HALF_WINDOW_SIZE = 512,
  parameter int SATURATE         = 1,
  localparam int BUS_SIZE        = LANES * WORD_LENGTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUS_SIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUS_SIZE-1:0] out_data,
  output logic                out_first,
  output logic                sat_flag
);

  localparam int BEATS_HALF = HALF_WINDOW_SIZE / LANES;
  localparam int CNT_W      = $clog2(2 * BEATS_HALF);
  localparam int IDX_W      = (BEATS_HALF > 1) ? $clog2(BEATS_HALF) : 1;
  localparam int W          = WORD_LENGTH;

  typedef enum logic {FIRST_HALF, SECOND_HALF} phase_t;

  phase_t              phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUS_SIZE-1:0] buf_q [BEATS_HALF];
  logic                out_valid_q;
  logic [BUS_SIZE-1:0] out_data_q;
  logic                out_first_q;
  logic                sat_flag_q;

  logic                accept;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [BUS_SIZE-1:0] sum_data;
  logic                any_ovf;
  logic [W:0]          lane_sum;
  logic                lane_ovf;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign sat_flag  = sat_flag_q;

  // In the first half a new beat overwrites the output register, so it may
  // only enter when that register is empty or draining this cycle.
  always_comb begin
    in_ready = 1'b0;
    case (phase_q)
      FIRST_HALF:  in_ready = !clear && (!out_valid_q || out_ready);
      SECOND_HALF: in_ready = !clear;
      default:     in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Next-state logic for phase and beat counter.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clear) begin
      phase_d = FIRST_HALF;
      cnt_d   = '0;
    end else if (accept) begin
      if (cnt_q == CNT_W'(2 * BEATS_HALF - 1)) cnt_d = '0;
      else                                     cnt_d = cnt_q + CNT_W'(1);
      case (phase_q)
        FIRST_HALF:  if (cnt_q == CNT_W'(BEATS_HALF - 1))     phase_d = SECOND_HALF;
        SECOND_HALF: if (cnt_q == CNT_W'(2 * BEATS_HALF - 1)) phase_d = FIRST_HALF;
        default:     phase_d = FIRST_HALF;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= FIRST_HALF;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // First-half beats read buffer slot cnt; second-half beats write slot
  // cnt-BEATS_HALF. Both indices always fall within the buffer.
  assign rd_idx = IDX_W'(cnt_q);
  assign wr_idx = IDX_W'(cnt_q - CNT_W'(BEATS_HALF));

  // Per-lane sum at W+1 bits; overflow when the two top bits disagree.
  always_comb begin
    sum_data = '0;
    any_ovf  = 1'b0;
    lane_sum = '0;
    lane_ovf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = {in_data[i*W + W-1], in_data[i*W +: W]}
               + {buf_q[rd_idx][i*W + W-1], buf_q[rd_idx][i*W +: W]};
      lane_ovf = lane_sum[W] ^ lane_sum[W-1];
      any_ovf  = any_ovf | lane_ovf;
      if (lane_ovf && (SATURATE != 0))
        sum_data[i*W +: W] = lane_sum[W] ? {1'b1, {(W-1){1'b0}}}
                                         : {1'b0, {(W-1){1'b1}}};
      else
        sum_data[i*W +: W] = lane_sum[W-1:0];
    end
  end

  // Output register: a new first-half result wins over draining, which
  // gives one beat per cycle when downstream is always ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else if (accept && (phase_q == FIRST_HALF)) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sum_data;
      out_first_q <= (cnt_q == '0);
      sat_flag_q  <= sat_flag_q | any_ovf;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
    end
  end

  // Overlap buffer: second half of the current frame, consumed next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BEATS_HALF; i++) buf_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < BEATS_HALF; i++) buf_q[i] <= '0;
    end else if (accept && (phase_q == SECOND_HALF)) begin
      buf_q[wr_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_overlap_add_stream.sv
// -----------------------------------------------------------------------------
// tb_overlap_add_stream
// Directed bench for overlap_add_stream with W=16, LANES=4, HALF_WINDOW=8
// (two beats per half). A saturating and a wrapping instance share stimulus.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge, where a monitor also records every completed output beat.
// -----------------------------------------------------------------------------
module tb_overlap_add_stream;

  localparam int W   = 16;
  localparam int L   = 4;
  localparam int HWS = 8;
  localparam int BUS = W * L;

  logic           clock = 1'b0;
  logic           reset;
  logic           clear;
  logic           in_valid;
  logic [BUS-1:0] in_data;
  logic           out_ready;

  logic           in_ready,  in_ready_w;
  logic           out_valid, out_valid_w;
  logic [BUS-1:0] out_data,  out_data_w;
  logic           out_first, out_first_w;
  logic           sat_flag,  sat_flag_w;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  logic [BUS:0] got_q[$];
  logic [BUS:0] got_w_q[$];
  logic [BUS:0] exp_q[$];
  logic [BUS:0] exp_w_q[$];

  overlap_add_stream #(.WORD_LENGTH(W), .LANES(L), .HALF_WINDOW_SIZE(HWS), .SATURATE(1)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .sat_flag(sat_flag)
  );

  overlap_add_stream #(.WORD_LENGTH(W), .LANES(L), .HALF_WINDOW_SIZE(HWS), .SATURATE(0)) dut_w (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_first(out_first_w), .sat_flag(sat_flag_w)
  );

  // Clock
  always #5 clock = ~clock;

  // Output monitor: a beat is transferred at the next rising edge.
  always @(negedge clock) begin
    if (out_valid && out_ready)   got_q.push_back({out_first, out_data});
    if (out_valid_w && out_ready) got_w_q.push_back({out_first_w, out_data_w});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BUS-1:0] rep(input logic [W-1:0] w);
    return {L{w}};
  endfunction

  function automatic logic [BUS:0] ob(input logic f, input logic [BUS-1:0] d);
    return {f, d};
  endfunction

  // Driver: present one beat, wait for acceptance (bounded), end 1 after edge.
  task automatic send_beat(input logic [BUS-1:0] d);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clock);
    while (!in_ready && waited < 50) begin
      stalls++;
      waited++;
      @(negedge clock);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    n_checks++; if (out_first !== 1'b0) begin n_fail++; $display("FAIL reset_out_first: got %b required 0", out_first); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %b required 0", sat_flag); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_frame_a();
    got_q.delete();
    exp_q = '{ob(1'b1, rep(16'h0001)), ob(1'b0, rep(16'h0002))};
    send_beat(rep(16'h0001)); send_beat(rep(16'h0002));
    send_beat(rep(16'h0005)); send_beat(rep(16'h0005));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL frame_a_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_a_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_frame_b();
    got_q.delete();
    exp_q = '{ob(1'b1, rep(16'h000F)), ob(1'b0, rep(16'h000F))};
    send_beat(rep(16'h000A)); send_beat(rep(16'h000A));
    send_beat(rep(16'h0003)); send_beat(rep(16'h0003));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL frame_b_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL frame_b_sat_flag: got %b required 0", sat_flag); end
  endtask

  task automatic test_saturation();
    // Frame C loads 0x7000 / 0x8000 into the overlap buffer.
    got_q.delete();
    exp_q = '{ob(1'b1, rep(16'h0003)), ob(1'b0, rep(16'h0003))};
    send_beat(rep(16'h0000)); send_beat(rep(16'h0000));
    send_beat(rep(16'h7000)); send_beat(rep(16'h8000));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL frame_c_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_c_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_checks++; if (sat_flag_w !== 1'b0) begin n_fail++; $display("FAIL frame_c_sat_flag_wrap: got %b required 0", sat_flag_w); end
    // Frame D overflows in both directions.
    got_q.delete(); got_w_q.delete();
    exp_q   = '{ob(1'b1, rep(16'h7FFF)), ob(1'b0, rep(16'h8000))};
    exp_w_q = '{ob(1'b1, rep(16'h9000)), ob(1'b0, rep(16'h7FFF))};
    send_beat(rep(16'h2000)); send_beat(rep(16'hFFFF));
    send_beat(rep(16'h0000)); send_beat(rep(16'h0000));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sat_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_checks++;
    if (got_w_q.size() != exp_w_q.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d required %0d", got_w_q.size(), exp_w_q.size());
    end else begin
      for (int i = 0; i < exp_w_q.size(); i++) begin
        n_checks++;
        if (got_w_q[i] !== exp_w_q[i]) begin n_fail++; $display("FAIL wrap_beat%0d: got %h required %h", i, got_w_q[i], exp_w_q[i]); end
      end
    end
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_set: got %b required 1", sat_flag); end
    n_checks++; if (sat_flag_w !== 1'b1) begin n_fail++; $display("FAIL sat_flag_wrap_set: got %b required 1", sat_flag_w); end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    exp_q = '{ob(1'b1, rep(16'h0011)), ob(1'b0, rep(16'h0022))};
    send_beat(rep(16'h0011));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rep(16'h0022);
    repeat (3) begin
      @(negedge clock);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
      n_checks++; if (out_data !== rep(16'h0011)) begin n_fail++; $display("FAIL bp_out_data: got %h required %h", out_data, rep(16'h0011)); end
      n_checks++; if (out_first !== 1'b1) begin n_fail++; $display("FAIL bp_out_first: got %b required 1", out_first); end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send_beat(rep(16'h0022)); send_beat(rep(16'h0100)); send_beat(rep(16'h0200));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    got_q.delete();
    stalls = 0;
    exp_q = '{ob(1'b1, rep(16'h0101)), ob(1'b0, rep(16'h0202)),
              ob(1'b1, {16'h0014, 16'h0013, 16'h0012, 16'h0011}), ob(1'b0, rep(16'h0024))};
    t0 = $time;
    send_beat(rep(16'h0001)); send_beat(rep(16'h0002));
    send_beat(rep(16'h0010)); send_beat(rep(16'h0020));
    send_beat({16'h0004, 16'h0003, 16'h0002, 16'h0001}); send_beat(rep(16'h0004));
    send_beat(rep(16'h0030)); send_beat(rep(16'h0040));
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d required 0", stalls); end
    n_checks++; if (($time - t0) != 80) begin n_fail++; $display("FAIL b2b_duration: got %0t required 80", $time - t0); end
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_clear();
    got_q.delete();
    send_beat(rep(16'h0001)); send_beat(rep(16'h0001));
    out_ready = 1'b0;
    send_beat(rep(16'h0007));
    // cnt=3 with the 0x0041 result still pending.
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL clr_sat_before: got %b required 1", sat_flag); end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = rep(16'h0009);
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready: got %b required 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_pending: got %b required 1", out_valid); end
    @(posedge clock);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_first !== 1'b0) begin n_fail++; $display("FAIL clr_out_first: got %b required 0", out_first); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL clr_sat_flag: got %b required 0", sat_flag); end
    n_checks++; if (sat_flag_w !== 1'b0) begin n_fail++; $display("FAIL clr_sat_flag_wrap: got %b required 0", sat_flag_w); end
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL clr_drained_count: got %0d required 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== ob(1'b1, rep(16'h0031))) begin n_fail++; $display("FAIL clr_drained_beat: got %h required %h", got_q[0], ob(1'b1, rep(16'h0031))); end
    end
    out_ready = 1'b1;
    got_q.delete();
    exp_q = '{ob(1'b1, {16'h0004, 16'h0003, 16'h0002, 16'h0001}), ob(1'b0, rep(16'h0050))};
    send_beat({16'h0004, 16'h0003, 16'h0002, 16'h0001}); send_beat(rep(16'h0050));
    send_beat(rep(16'h0066)); send_beat(rep(16'h0066));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL post_clr_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_clr_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_beat(rep(16'h0123));
    n_checks++; if (out_data !== rep(16'h0189)) begin n_fail++; $display("FAIL ar_pre_data: got %h required %h", out_data, rep(16'h0189)); end
    #2;
    reset = 1'b1;
    #1;
    // Still in the high clock phase: no edge since reset rose.
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL ar_out_data: got %h required 0", out_data); end
    n_checks++; if (out_first !== 1'b0) begin n_fail++; $display("FAIL ar_out_first: got %b required 0", out_first); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    got_q.delete();
    exp_q = '{ob(1'b1, rep(16'h0001)), ob(1'b0, rep(16'h0002))};
    send_beat(rep(16'h0001)); send_beat(rep(16'h0002));
    send_beat(rep(16'h0005)); send_beat(rep(16'h0005));
    settle();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL post_ar_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_ar_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a();
    test_frame_b();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overlap_add_stream.md
Name: overlap_add_stream

Overview:
- Parametrised overlap-add stage for the MPEG-2 AAC decoder. Sits after the IMDCT/windowing output and produces PCM.
- Accepts windowed frames of 2*HALF_WINDOW_SIZE signed samples as beats of LANES samples.
- Adds the first half of each frame to the stored second half of the previous frame and streams the result out.
- Generalises the 4-lane, 16-bit load/add unit with configurable width, lane count and window depth, valid/ready flow control, an internal overlap buffer, optional saturation and a frame clear.

Parameters:
WORD_LENGTH, 16, signed sample width in bits
LANES, 4, samples per bus beat
HALF_WINDOW_SIZE, 512, samples per half window; must be a multiple of LANES
SATURATE, 1, 1 = clamp sums to the signed range, 0 = wrap modulo 2^WORD_LENGTH
(derived) BEATS_HALF = HALF_WINDOW_SIZE/LANES; BUS_SIZE = LANES*WORD_LENGTH

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous frame clear: zero overlap buffer, restart frame
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  BUS_SIZE  lane i = bits [(i+1)*WORD_LENGTH-1 : i*WORD_LENGTH], signed
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat when out_valid && out_ready
out_data  out  BUS_SIZE  overlap-added PCM, same lane packing
out_first  out  1  high with out_valid on the first output beat of a frame
sat_flag  out  1  sticky: some lane saturated or wrapped since the last reset/clear

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_first=0, sat_flag=0, beat counter=0, phase=FIRST_HALF, all overlap-buffer entries read as 0.
- Beat counter cnt runs 0..2*BEATS_HALF-1 and wraps to 0 after the last accepted beat of a frame.
- Phase FIRST_HALF (cnt < BEATS_HALF):
  - in_ready = !clear && (!out_valid || out_ready).
  - On accept, each lane is summed: sum_i = in_lane_i + buf[cnt].lane_i at WORD_LENGTH+1 bits, signed.
  - SATURATE=1: clamp to [-2^(W-1), 2^(W-1)-1]. SATURATE=0: keep the low W bits.
  - Result is registered to out_data; out_valid=1; out_first = (cnt==0).
  - Latency is 1 cycle from accept to out_valid.
  - sat_flag is set if any lane overflowed (both modes).
- Phase SECOND_HALF (cnt >= BEATS_HALF):
  - in_ready = !clear.
  - On accept, buf[cnt-BEATS_HALF] <= in_data. No output is produced.
  - A pending out_valid still drains normally.
- Output register:
  - Clears out_valid when out_valid && out_ready and no new FIRST_HALF accept occurs.
  - Accept and drain in the same cycle: the new beat replaces the old one, out_valid stays 1. Full throughput is 1 beat/cycle.
  - out_data and out_first are held stable while out_valid && !out_ready.
- First frame after reset/clear: the buffer is zero, so output equals the input first half (saturation cannot occur).
- clear has priority over a handshake:
  - No input is accepted in that cycle.
  - cnt=0, phase=FIRST_HALF, all buffer entries zero, out_valid=0 (pending beat discarded), out_first=0, sat_flag=0.
- Reset mid-frame: the partial frame is lost and the buffer is zeroed.
- Phase sequence: FIRST_HALF -> SECOND_HALF on accept at cnt=BEATS_HALF-1; SECOND_HALF -> FIRST_HALF on accept at cnt=2*BEATS_HALF-1.
- No input is accepted while in_valid=0; the counter holds.

Test Plan:
(Parameters for all scenarios: WORD_LENGTH=16, LANES=4, HALF_WINDOW_SIZE=8, so BEATS_HALF=2.)
1. After reset, frame A: beats 0-1 all lanes 0x0001/0x0002, beats 2-3 all lanes 0x0005 -> outputs 0x0001 (out_first=1) then 0x0002. Exactly 2 output beats.
2. Frame B after A: first-half lanes 0x000A -> outputs 0x000F, 0x000F; out_first on the first beat only.
3. Stored 0x7000 + incoming 0x2000 -> 0x7FFF and sat_flag=1. Stored 0x8000 + 0xFFFF -> 0x8000. With SATURATE=0, 0x7000+0x2000 -> 0x9000 and sat_flag=1.
4. out_ready held low 3 cycles during the first half -> in_ready=0, out_data stable. With continuous valid/ready, full-rate streaming at 1 beat/cycle with no loss or duplication.
5. clear asserted at cnt=3 with out_valid=1 -> next cycle out_valid=0 and sat_flag=0. The next frame outputs equal its inputs (buffer zero).
6. reset pulsed asynchronously mid-FIRST_HALF -> out_valid/out_data zero without a clock edge. A subsequent frame behaves as in test 1.
